// File: rtl/regfile_scoreboard.sv
// -----------------------------------------------------------------------------
// regfile_scoreboard
// Integer register file with a per-register pending (scoreboard) bit.
// Index 0 is hardwired to zero and is never busy. Reads are combinational,
// with optional same-cycle forwarding of writeback data.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous, active-low reset
//   rs1, rs2   read-port register indices
//   op_a, op_b read data for rs1 / rs2
//   rs1_busy,  pending-write status of rs1 / rs2
//   rs2_busy
//   wb_en      writeback strobe; wb_rd destination, wb_data value
//   iss_en     issue strobe; marks iss_rd as pending
//   flush      synchronous clear of all pending bits
//   pend_cnt   registered count of pending registers
// -----------------------------------------------------------------------------
module regfile_scoreboard #(
   parameter int XLEN   = 32,
   parameter int NREG   = 32,
   parameter int BYPASS = 1,
   localparam int AW    = $clog2(NREG)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [AW-1:0]   rs1,
   input  logic [AW-1:0]   rs2,
   output logic [XLEN-1:0] op_a,
   output logic [XLEN-1:0] op_b,
   output logic            rs1_busy,
   output logic            rs2_busy,
   input  logic            wb_en,
   input  logic [AW-1:0]   wb_rd,
   input  logic [XLEN-1:0] wb_data,
   input  logic            iss_en,
   input  logic [AW-1:0]   iss_rd,
   input  logic            flush,
   output logic [AW:0]     pend_cnt
);

   // Entry 0 exists only so indices map directly; it is never written and the
   // read path masks it, so synthesis reduces it to constants.
   logic [XLEN-1:0] r_regs [NREG];
   logic [NREG-1:0] r_pend;
   logic [AW:0]     r_pend_cnt;

   logic            w_wb_act;
   logic            w_iss_act;
   logic [NREG-1:0] w_pend_nxt;
   logic [AW:0]     w_cnt_nxt;

   assign w_wb_act  = wb_en  && (wb_rd  != '0);
   assign w_iss_act = iss_en && (iss_rd != '0);

   // Next pending vector: writeback clears, issue sets (issue wins on a tie),
   // flush overrides both.
   always_comb begin
      // NOTE: every variable written here gets a default first, so no path
      // leaves it unassigned and no latch is inferred.
      w_pend_nxt = r_pend;
      if (w_wb_act)
         w_pend_nxt[wb_rd] = 1'b0;
      if (w_iss_act)
         w_pend_nxt[iss_rd] = 1'b1;
      if (flush)
         w_pend_nxt = '0;
      w_pend_nxt[0] = 1'b0;
   end

   // Population count of the next pending vector, so pend_cnt tracks the
   // pending bits exactly after every edge.
   always_comb begin
      w_cnt_nxt = '0;
      for (int i = 1; i < NREG; i++)
         w_cnt_nxt = w_cnt_nxt + {{AW{1'b0}}, w_pend_nxt[i]};
   end

   // NOTE: the data array is reset explicitly because reads of an unwritten
   // register must return 0; this keeps it in flops rather than RAM macros.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < NREG; i++)
            r_regs[i] <= '0;
         r_pend     <= '0;
         r_pend_cnt <= '0;
      end else begin
         // NOTE: non-blocking assignments so every flop samples pre-edge values.
         if (w_wb_act)
            r_regs[wb_rd] <= wb_data;
         r_pend     <= w_pend_nxt;
         r_pend_cnt <= w_cnt_nxt;
      end
   end

   // Read ports
   logic w_fwd_a, w_fwd_b;
   logic w_keep_a, w_keep_b;

   assign w_fwd_a  = (BYPASS != 0) && w_wb_act && (wb_rd == rs1);
   assign w_fwd_b  = (BYPASS != 0) && w_wb_act && (wb_rd == rs2);
   // A same-edge issue to the forwarded index keeps the register busy.
   assign w_keep_a = w_iss_act && (iss_rd == rs1);
   assign w_keep_b = w_iss_act && (iss_rd == rs2);

   assign op_a = (rs1 == '0) ? '0 : (w_fwd_a ? wb_data : r_regs[rs1]);
   assign op_b = (rs2 == '0) ? '0 : (w_fwd_b ? wb_data : r_regs[rs2]);

   assign rs1_busy = (rs1 != '0) && r_pend[rs1] && !(w_fwd_a && !w_keep_a);
   assign rs2_busy = (rs2 != '0) && r_pend[rs2] && !(w_fwd_b && !w_keep_b);

   assign pend_cnt = r_pend_cnt;

endmodule

// File: tb/tb_regfile_scoreboard.sv
module tb_regfile_scoreboard;

   localparam int XLEN = 32;
   localparam int NREG = 32;
   localparam int AW   = 5;

   logic            clk;
   logic            rst;
   logic [AW-1:0]   rs1, rs2;
   logic            wb_en;
   logic [AW-1:0]   wb_rd;
   logic [XLEN-1:0] wb_data;
   logic            iss_en;
   logic [AW-1:0]   iss_rd;
   logic            flush;

   // Forwarding instance
   logic [XLEN-1:0] b_op_a, b_op_b;
   logic            b_busy1, b_busy2;
   logic [AW:0]     b_cnt;
   // Non-forwarding instance
   logic [XLEN-1:0] n_op_a, n_op_b;
   logic            n_busy1, n_busy2;
   logic [AW:0]     n_cnt;

   int checks = 0;
   int errors = 0;

   regfile_scoreboard #(.XLEN(XLEN), .NREG(NREG), .BYPASS(1)) u_byp (
      .clk(clk), .rst(rst), .rs1(rs1), .rs2(rs2),
      .op_a(b_op_a), .op_b(b_op_b), .rs1_busy(b_busy1), .rs2_busy(b_busy2),
      .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data),
      .iss_en(iss_en), .iss_rd(iss_rd), .flush(flush), .pend_cnt(b_cnt)
   );

   regfile_scoreboard #(.XLEN(XLEN), .NREG(NREG), .BYPASS(0)) u_nobyp (
      .clk(clk), .rst(rst), .rs1(rs1), .rs2(rs2),
      .op_a(n_op_a), .op_b(n_op_b), .rs1_busy(n_busy1), .rs2_busy(n_busy2),
      .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data),
      .iss_en(iss_en), .iss_rd(iss_rd), .flush(flush), .pend_cnt(n_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic idle();
      wb_en   = 1'b0;
      wb_rd   = '0;
      wb_data = '0;
      iss_en  = 1'b0;
      iss_rd  = '0;
      flush   = 1'b0;
   endtask

   // Apply the currently driven inputs across one rising edge, then return
   // just after the next falling edge with all strobes dropped.
   task automatic step();
      @(posedge clk);
      @(negedge clk);
      idle();
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      idle();
      #3;
      for (int i = 0; i < NREG; i++) begin
         rs1 = 5'(i);
         rs2 = 5'(NREG - 1 - i);
         #1;
         checks++;
         if (b_op_a !== 32'h0 || b_op_b !== 32'h0 || b_busy1 !== 1'b0 || b_busy2 !== 1'b0 ||
             n_op_a !== 32'h0 || n_busy1 !== 1'b0) begin
            errors++;
            $display("FAIL reset_read idx=%0d op_a=%h op_b=%h busy=%b%b nop_a=%h required 0", i,
                     b_op_a, b_op_b, b_busy1, b_busy2, n_op_a);
         end
      end
      checks++;
      if (b_cnt !== 6'd0 || n_cnt !== 6'd0) begin
         errors++;
         $display("FAIL reset_cnt got %0d/%0d required 0", b_cnt, n_cnt);
      end
      @(negedge clk);
      rst = 1'b1;
      #1;
   endtask

   task automatic test_bypass();
      rs1 = 5'd5;
      wb_en = 1'b1; wb_rd = 5'd5; wb_data = 32'hDEADBEEF;
      #1;
      checks++;
      if (b_op_a !== 32'hDEADBEEF) begin
         errors++;
         $display("FAIL bypass_same_cycle got %h required deadbeef", b_op_a);
      end
      checks++;
      if (n_op_a !== 32'h0) begin
         errors++;
         $display("FAIL nobypass_old_value got %h required 00000000", n_op_a);
      end
      step();
      checks++;
      if (b_op_a !== 32'hDEADBEEF || n_op_a !== 32'hDEADBEEF) begin
         errors++;
         $display("FAIL write_next_cycle got %h/%h required deadbeef", b_op_a, n_op_a);
      end
   endtask

   task automatic test_pending();
      rs2 = 5'd7;
      iss_en = 1'b1; iss_rd = 5'd7;
      #1;
      checks++;
      if (b_busy2 !== 1'b0) begin
         errors++;
         $display("FAIL issue_not_yet_busy got %b required 0", b_busy2);
      end
      step();
      checks++;
      if (b_busy2 !== 1'b1 || n_busy2 !== 1'b1 || b_cnt !== 6'd1) begin
         errors++;
         $display("FAIL issue_busy busy=%b/%b cnt=%0d required 1/1 cnt=1", b_busy2, n_busy2, b_cnt);
      end
      wb_en = 1'b1; wb_rd = 5'd7; wb_data = 32'h0000_0077;
      #1;
      checks++;
      if (b_busy2 !== 1'b0 || b_op_b !== 32'h77 || n_busy2 !== 1'b1 || n_op_b !== 32'h0) begin
         errors++;
         $display("FAIL wb_forward busy=%b op=%h nbusy=%b nop=%h required 0 77 1 0",
                  b_busy2, b_op_b, n_busy2, n_op_b);
      end
      step();
      checks++;
      if (b_busy2 !== 1'b0 || n_busy2 !== 1'b0 || b_cnt !== 6'd0 || n_cnt !== 6'd0 ||
          n_op_b !== 32'h77) begin
         errors++;
         $display("FAIL wb_clear busy=%b/%b cnt=%0d/%0d op=%h required 0/0 0/0 77",
                  b_busy2, n_busy2, b_cnt, n_cnt, n_op_b);
      end
      // Writeback to a register that is not pending: data lands, bit stays 0.
      rs2 = 5'd8;
      wb_en = 1'b1; wb_rd = 5'd8; wb_data = 32'h0000_0088;
      step();
      checks++;
      if (n_op_b !== 32'h88 || n_busy2 !== 1'b0 || n_cnt !== 6'd0) begin
         errors++;
         $display("FAIL wb_nonpending op=%h busy=%b cnt=%0d required 88 0 0", n_op_b, n_busy2, n_cnt);
      end
   endtask

   task automatic test_same_edge();
      rs1 = 5'd9;
      iss_en = 1'b1; iss_rd = 5'd9;
      step();
      // Re-issue to an already-pending register: still a single pending bit.
      iss_en = 1'b1; iss_rd = 5'd9;
      step();
      checks++;
      if (b_cnt !== 6'd1) begin
         errors++;
         $display("FAIL reissue_cnt got %0d required 1", b_cnt);
      end
      iss_en = 1'b1; iss_rd = 5'd9;
      wb_en = 1'b1; wb_rd = 5'd9; wb_data = 32'h0000_0099;
      #1;
      checks++;
      if (b_busy1 !== 1'b1 || b_op_a !== 32'h99) begin
         errors++;
         $display("FAIL same_edge_comb busy=%b op=%h required 1 99", b_busy1, b_op_a);
      end
      step();
      checks++;
      if (n_op_a !== 32'h99 || b_busy1 !== 1'b1 || n_busy1 !== 1'b1 || b_cnt !== 6'd1) begin
         errors++;
         $display("FAIL same_edge_after op=%h busy=%b/%b cnt=%0d required 99 1/1 1",
                  n_op_a, b_busy1, n_busy1, b_cnt);
      end
      wb_en = 1'b1; wb_rd = 5'd9; wb_data = 32'h0000_0999;
      step();
   endtask

   task automatic test_zero();
      rs1 = 5'd0; rs2 = 5'd0;
      wb_en = 1'b1; wb_rd = 5'd0; wb_data = 32'hFFFF_FFFF;
      iss_en = 1'b1; iss_rd = 5'd0;
      #1;
      checks++;
      if (b_op_a !== 32'h0 || b_busy1 !== 1'b0 || b_op_b !== 32'h0) begin
         errors++;
         $display("FAIL zero_comb op=%h busy=%b required 0 0", b_op_a, b_busy1);
      end
      step();
      checks++;
      if (b_op_a !== 32'h0 || n_op_a !== 32'h0 || b_busy1 !== 1'b0 || b_cnt !== 6'd0) begin
         errors++;
         $display("FAIL zero_after op=%h/%h busy=%b cnt=%0d required 0 0 0", b_op_a, n_op_a, b_busy1, b_cnt);
      end
   endtask

   task automatic test_flush();
      for (int i = 1; i < NREG; i++) begin
         iss_en = 1'b1; iss_rd = 5'(i);
         step();
         checks++;
         if (b_cnt !== 6'(i)) begin
            errors++;
            $display("FAIL fill_cnt step=%0d got %0d required %0d", i, b_cnt, i);
         end
      end
      for (int i = 1; i < NREG; i++) begin
         rs1 = 5'(i);
         #1;
         checks++;
         if (b_busy1 !== 1'b1) begin
            errors++;
            $display("FAIL fill_busy idx=%0d got %b required 1", i, b_busy1);
         end
      end
      flush = 1'b1;
      iss_en = 1'b1; iss_rd = 5'd3;
      wb_en = 1'b1; wb_rd = 5'd4; wb_data = 32'h0000_0044;
      step();
      checks++;
      if (b_cnt !== 6'd0 || n_cnt !== 6'd0) begin
         errors++;
         $display("FAIL flush_cnt got %0d/%0d required 0", b_cnt, n_cnt);
      end
      for (int i = 0; i < NREG; i++) begin
         rs1 = 5'(i);
         #1;
         checks++;
         if (b_busy1 !== 1'b0 || n_busy1 !== 1'b0) begin
            errors++;
            $display("FAIL flush_busy idx=%0d got %b/%b required 0", i, b_busy1, n_busy1);
         end
      end
      rs1 = 5'd4;
      #1;
      checks++;
      if (n_op_a !== 32'h44) begin
         errors++;
         $display("FAIL flush_wb_data got %h required 44", n_op_a);
      end
   endtask

   task automatic test_reset_mid();
      iss_en = 1'b1; iss_rd = 5'd11;
      step();
      wb_en = 1'b1; wb_rd = 5'd12; wb_data = 32'h1234_5678;
      step();
      // Operations in flight when reset asserts between edges.
      rs1 = 5'd12; rs2 = 5'd11;
      iss_en = 1'b1; iss_rd = 5'd13;
      wb_en = 1'b1; wb_rd = 5'd12; wb_data = 32'hCAFE_F00D;
      #1;
      rst = 1'b0;
      #1;
      checks++;
      if (n_op_a !== 32'h0 || n_busy2 !== 1'b0 || b_cnt !== 6'd0 || n_cnt !== 6'd0) begin
         errors++;
         $display("FAIL reset_async op=%h busy=%b cnt=%0d/%0d required 0", n_op_a, n_busy2, b_cnt, n_cnt);
      end
      @(posedge clk);
      #1;
      checks++;
      if (n_op_a !== 32'h0 || b_cnt !== 6'd0) begin
         errors++;
         $display("FAIL reset_discard op=%h cnt=%0d required 0 0", n_op_a, b_cnt);
      end
      @(negedge clk);
      idle();
      rst = 1'b1;
      #1;
      rs1 = 5'd5;
      #1;
      checks++;
      if (n_op_a !== 32'h0) begin
         errors++;
         $display("FAIL reset_data5 got %h required 0", n_op_a);
      end
      iss_en = 1'b1; iss_rd = 5'd2;
      wb_en = 1'b1; wb_rd = 5'd6; wb_data = 32'h0000_0066;
      rs2 = 5'd2; rs1 = 5'd6;
      step();
      checks++;
      if (b_cnt !== 6'd1 || b_busy2 !== 1'b1 || n_op_a !== 32'h66) begin
         errors++;
         $display("FAIL resume cnt=%0d busy=%b op=%h required 1 1 66", b_cnt, b_busy2, n_op_a);
      end
   endtask

   initial begin
      rs1 = '0;
      rs2 = '0;
      test_reset();
      test_bypass();
      test_pending();
      test_same_edge();
      test_zero();
      test_flush();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
